// File: rtl/mat_result_streamer.sv
// mat_result_streamer
// Captures the matrix multiplier's flat product bus on a rising edge of
// finish and replays the active size x size sub-matrix as a row-major
// valid/ready element stream, so the multiplier can start its next job.
module mat_result_streamer #(
    parameter int MAX_SIZE     = 13,
    parameter int SQU_MAX_SIZE = 169,
    parameter int DATA_BW      = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               finish,
    input  logic [SQU_MAX_SIZE*2*DATA_BW-1:0]  data_in,
    input  logic [3:0]                         size,
    input  logic                               out_ready,
    output logic                               out_valid,
    output logic [2*DATA_BW-1:0]               out_data,
    output logic [3:0]                         out_row,
    output logic [3:0]                         out_col,
    output logic                               out_last,
    output logic                               busy,
    output logic                               done,
    output logic                               overrun
);

    localparam int         ELEM_W = 2 * DATA_BW;
    localparam int         IDX_W  = $clog2(SQU_MAX_SIZE);
    localparam logic [3:0] MAX_N  = 4'(MAX_SIZE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                          state;
    state_t                          state_nxt;
    logic                            finish_prev;
    logic                            fin_edge;
    logic                            capture;
    logic                            hs;
    logic                            at_last;
    logic [SQU_MAX_SIZE*ELEM_W-1:0]  cap;
    logic [3:0]                      n;
    logic [3:0]                      row;
    logic [3:0]                      col;
    logic [IDX_W-1:0]                elem_idx;
    int                              elem_base;

    // A held-high finish produces exactly one edge; only an edge seen in IDLE captures.
    assign fin_edge  = finish & ~finish_prev;
    assign capture   = (state == S_IDLE) && fin_edge;
    assign hs        = (state == S_STREAM) && out_ready;
    assign at_last   = (row == n - 4'd1) && (col == n - 4'd1);
    assign elem_idx  = IDX_W'(row) * IDX_W'(MAX_SIZE) + IDX_W'(col);
    assign elem_base = int'(elem_idx) * ELEM_W;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: IDLE -> STREAM on capture, STREAM -> DONE on the last handshake.
    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned and infers a latch.
        state_nxt = state;
        case (state)
            S_IDLE:   if (capture) state_nxt = S_STREAM;
            S_STREAM: if (hs && at_last) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output decode: stream outputs are driven only in STREAM, zero elsewhere.
    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        out_data  = '0;
        out_row   = '0;
        out_col   = '0;
        out_last  = 1'b0;
        case (state)
            S_STREAM: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = cap[elem_base +: ELEM_W];
                out_row   = row;
                out_col   = col;
                out_last  = at_last;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Edge history, latched size, row-major position and the sticky overrun flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            finish_prev <= 1'b0;
            n           <= MAX_N;
            row         <= '0;
            col         <= '0;
            overrun     <= 1'b0;
        end else begin
            finish_prev <= finish;
            if (fin_edge && state == S_STREAM) begin
                overrun <= 1'b1;
            end
            if (capture) begin
                n   <= (size == 4'd0 || size > MAX_N) ? MAX_N : size;
                row <= '0;
                col <= '0;
            end else if (hs && !at_last) begin
                if (col == n - 4'd1) begin
                    col <= '0;
                    row <= row + 4'd1;
                end else begin
                    col <= col + 4'd1;
                end
            end
        end
    end

    // Product capture.
    // NOTE: this wide register is deliberately not reset; it is read only in STREAM, which is always entered through a capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            cap <= data_in;
        end
    end

endmodule

// File: tb/tb_mat_result_streamer.sv
// Scoreboard bench for mat_result_streamer: the stimulus pushes the expected
// row-major beats derived from a matrix array, a monitor pops on handshakes.
module tb_mat_result_streamer;

    localparam int MAX_SIZE = 13;
    localparam int SQU      = 169;
    localparam int DATA_BW  = 16;
    localparam int EW       = 2 * DATA_BW;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              finish = 1'b0;
    logic              out_ready = 1'b0;
    logic [SQU*EW-1:0] data_in = '0;
    logic [3:0]        size = '0;
    logic              out_valid;
    logic [EW-1:0]     out_data;
    logic [3:0]        out_row;
    logic [3:0]        out_col;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              overrun;

    mat_result_streamer #(
        .MAX_SIZE     (MAX_SIZE),
        .SQU_MAX_SIZE (SQU),
        .DATA_BW      (DATA_BW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .finish    (finish),
        .data_in   (data_in),
        .size      (size),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [EW-1:0] data;
        int            row;
        int            col;
        bit            last;
    } beat_t;

    beat_t         sb[$];
    logic [EW-1:0] mat [SQU];
    int            vectors    = 0;
    int            miscompares = 0;
    int            ready_mode = 0;
    int            hs_count   = 0;
    int            tput_exp   = 0;
    int            run_len    = 0;
    bit            exp_done   = 1'b0;
    bit            ovr_exp    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the active sub-matrix in row-major order.
    function automatic int push_expected(input logic [3:0] sz);
        int    n;
        beat_t b;
        n = (sz == 4'd0 || sz > 4'd13) ? MAX_SIZE : int'(sz);
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                b.data = mat[r * MAX_SIZE + c];
                b.row  = r;
                b.col  = c;
                b.last = (r == n - 1) && (c == n - 1);
                sb.push_back(b);
            end
        end
        return n;
    endfunction

    task automatic drive_bus();
        for (int i = 0; i < SQU; i++) data_in[i*EW +: EW] = mat[i];
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < SQU; i++) data_in[i*EW +: EW] = $urandom;
        size = 4'($urandom);
    endtask

    task automatic fill_product();
        int acc;
        for (int r = 0; r < MAX_SIZE; r++) begin
            for (int c = 0; c < MAX_SIZE; c++) begin
                acc = 0;
                for (int k = 0; k < MAX_SIZE; k++)
                    acc += (r * MAX_SIZE + k) * (SQU + k * MAX_SIZE + c);
                mat[r * MAX_SIZE + c] = EW'(acc);
            end
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < SQU; i++) mat[i] = $urandom;
    endtask

    task automatic start_stream(input logic [3:0] sz, input int mode, input bit hold, input int chk0);
        int n;
        n          = push_expected(sz);
        tput_exp   = (mode == 0) ? n * n : 0;
        ready_mode = mode;
        hs_count   = 0;
        drive_bus();
        @(posedge clk); #1;
        size   = sz;
        finish = 1'b1;
        @(negedge clk);
        check("latency_pre", out_valid, 0);
        @(negedge clk);
        check("latency_first", out_valid, 1);
        if (chk0 >= 0) check("c00_value", out_data, chk0);
        scramble_inputs();
        if (!hold) begin
            @(posedge clk); #1;
            finish = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid && !done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle_timeout: %0d beats still pending", sb.size());
            sb.delete();
        end
    endtask

    // Downstream ready generator.
    initial begin
        logic [3:0] pat;
        int         ph;
        pat = 4'b1001;
        ph  = 0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       begin out_ready = pat[ph % 4]; ph++; end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares every presented beat with the scoreboard head.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_done = 1'b0;
                run_len  = 0;
            end else begin
                check("done", done, exp_done);
                exp_done = 1'b0;
                if (done) begin
                    check("done_valid_low", out_valid, 0);
                    check("done_busy_low", busy, 0);
                    if (tput_exp != 0) check("throughput", run_len, tput_exp);
                    run_len = 0;
                end
                if (out_valid) begin
                    run_len++;
                    check("busy", busy, 1);
                    if (sb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_beat: row %0d col %0d data 0x%0h, none expected",
                                 out_row, out_col, out_data);
                    end else begin
                        b = sb[0];
                        check("data", out_data, b.data);
                        check("row", out_row, b.row);
                        check("col", out_col, b.col);
                        check("last", out_last, b.last);
                        if (out_ready) begin
                            void'(sb.pop_front());
                            hs_count++;
                            if (b.last) exp_done = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Stimulus.
    initial begin
        bit reached;
        #3;
        check("reset_outputs", {out_valid, out_data, out_row, out_col, out_last, busy, done, overrun}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_valid", out_valid, 0);

        // Matrix product, full size, continuous ready.
        fill_product();
        start_stream(4'd13, 0, 1'b0, 21632);
        wait_idle();

        // Top-left 3x3 of the same product.
        start_stream(4'd3, 0, 1'b0, -1);
        wait_idle();

        // Ready pattern 1,0,0,1.
        start_stream(4'd13, 1, 1'b0, -1);
        wait_idle();

        // Finish held high for 400 cycles: exactly one stream.
        fill_random();
        start_stream(4'd13, 0, 1'b1, -1);
        repeat (398) @(posedge clk);
        #1 finish = 1'b0;
        wait_idle();
        check("hold_all_beats", sb.size(), 0);
        check("hold_no_overrun", overrun, ovr_exp);

        // Second edge during a stream: ignored, sets overrun.
        fill_random();
        start_stream(4'd13, 2, 1'b0, -1);
        repeat (20) @(posedge clk);
        #1;
        scramble_inputs();
        finish = 1'b1;
        @(posedge clk); #1;
        finish  = 1'b0;
        ovr_exp = 1'b1;
        @(negedge clk);
        check("overrun_set", overrun, ovr_exp);
        wait_idle();
        check("overrun_sticky", overrun, ovr_exp);

        // Out-of-range sizes map to the full matrix.
        fill_random();
        start_stream(4'd0, 2, 1'b0, -1);
        wait_idle();
        fill_random();
        start_stream(4'd15, 2, 1'b0, -1);
        wait_idle();

        // Random sizes and data.
        for (int t = 0; t < 3; t++) begin
            fill_random();
            start_stream(4'($urandom_range(1, 13)), 2, 1'b0, -1);
            wait_idle();
        end

        // Reset in the middle of a stream, then restart from (0,0).
        fill_random();
        start_stream(4'd13, 0, 1'b0, -1);
        reached = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (hs_count >= 50) begin
                reached = 1'b1;
                break;
            end
        end
        check("reach_element_50", reached, 1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("midstream_reset_outputs",
              {out_valid, out_data, out_row, out_col, out_last, busy, done, overrun}, 0);
        sb.delete();
        ovr_exp  = 1'b0;
        tput_exp = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("overrun_after_reset", overrun, ovr_exp);
        fill_random();
        start_stream(4'd5, 2, 1'b0, -1);
        wait_idle();
        check("final_overrun", overrun, ovr_exp);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
